// File: rtl/replacement_pkg.sv
// Shared types and helpers for the set-associative true-LRU replacement unit.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// The per-set state struct is sized for the largest supported associativity
// (16 ways, 4-bit ages). This lets one package type serve every legal
// parameterisation. Lanes at or above ASSOCIATIVITY keep their reset value
// forever, and victim selection never looks at them.
package replacement_pkg;

   localparam int DEFAULT_ASSOCIATIVITY  = 4;
   localparam int DEFAULT_NUMBER_OF_SETS = 8;

   localparam int MAX_ASSOCIATIVITY = 16;
   localparam int MAX_WAY_WIDTH     = 4;

   // ceil(log2(value)), but never less than 1, so that a single-set build
   // still has a one-bit set index port.
   function automatic int clog2_min1(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   typedef logic [MAX_WAY_WIDTH-1:0] age_t;

   // age[i]  : recency rank of way i (0 = most recent)
   // valid[i]: way i currently holds a line
   typedef struct packed {
      age_t [MAX_ASSOCIATIVITY-1:0] age;
      logic [MAX_ASSOCIATIVITY-1:0] valid;
   } set_state_t;

   // Ages form the identity permutation and every way is invalid. Unused
   // upper lanes get distinct ages too, so they can never alias the oldest
   // age of a smaller configuration.
   function automatic set_state_t reset_set_state();
      set_state_t st;
      st.valid = '0;
      for (int i = 0; i < MAX_ASSOCIATIVITY; i++) begin
         st.age[i] = age_t'(i);
      end
      return st;
   endfunction

endpackage

// File: rtl/lru_set_update.sv
// Next-state logic for one LRU set: applies an access, then an invalidate.
// Latency: purely combinational; the caller registers the result.
// Backpressure: none; both events are always accepted in the same cycle.
//
// Ports:
//   state_i          current registered state of this set
//   access_en_i      hit or fill of access_way_i this cycle (already set-gated)
//   access_way_i     way being accessed
//   invalidate_en_i  invalidation of invalidate_way_i (already set-gated)
//   invalidate_way_i way being invalidated
//   state_o          state to load at the next clock edge
module lru_set_update
   import replacement_pkg::*;
#(
   parameter int ASSOCIATIVITY = DEFAULT_ASSOCIATIVITY,
   parameter int WAY_WIDTH     = $clog2(ASSOCIATIVITY)
) (
   input  set_state_t           state_i,
   input  logic                 access_en_i,
   input  logic [WAY_WIDTH-1:0] access_way_i,
   input  logic                 invalidate_en_i,
   input  logic [WAY_WIDTH-1:0] invalidate_way_i,
   output set_state_t           state_o
);

   localparam age_t AGE_OLDEST = age_t'(ASSOCIATIVITY - 1);

   set_state_t after_access;
   age_t       access_age;
   age_t       invalidate_age;

   // Access stage: the touched way becomes youngest, and every way that was
   // younger than it ages by one. Ways that were older keep their rank, so
   // the ages stay a permutation.
   always_comb begin
      after_access = state_i;
      access_age   = '0;
      for (int i = 0; i < ASSOCIATIVITY; i++) begin
         if (WAY_WIDTH'(i) == access_way_i) begin
            access_age = state_i.age[i];
         end
      end
      if (access_en_i) begin
         for (int i = 0; i < ASSOCIATIVITY; i++) begin
            if (WAY_WIDTH'(i) == access_way_i) begin
               after_access.age[i]   = '0;
               after_access.valid[i] = 1'b1;
            end else if (state_i.age[i] < access_age) begin
               after_access.age[i] = state_i.age[i] + age_t'(1);
            end
         end
      end
   end

   // Invalidate stage: works on the post-access state. This makes an access
   // and an invalidate of the same way in one cycle net out to an invalid,
   // oldest way. Ways older than the invalidated one move up one rank to
   // close the gap it leaves.
   always_comb begin
      state_o        = after_access;
      invalidate_age = '0;
      for (int i = 0; i < ASSOCIATIVITY; i++) begin
         if (WAY_WIDTH'(i) == invalidate_way_i) begin
            invalidate_age = after_access.age[i];
         end
      end
      if (invalidate_en_i) begin
         for (int i = 0; i < ASSOCIATIVITY; i++) begin
            if (WAY_WIDTH'(i) == invalidate_way_i) begin
               state_o.age[i]   = AGE_OLDEST;
               state_o.valid[i] = 1'b0;
            end else if (after_access.age[i] > invalidate_age) begin
               state_o.age[i] = after_access.age[i] - age_t'(1);
            end
         end
      end
   end

endmodule

// File: rtl/set_associative_replacement_unit.sv
// Per-set true-LRU victim selection with valid tracking for a set-assoc cache.
// Latency: updates land one cycle after the enable; lookup is zero-cycle (comb).
// Backpressure: none; access and invalidate are accepted every cycle.
//
// Ports:
//   clock            rising-edge clock for all state
//   reset            asynchronous active-low reset; clears every set
//   accessEnable     hit/fill of accessWay in accessSet
//   accessSet/Way    location of the access
//   invalidateEnable invalidation of invalidateWay in invalidateSet
//   invalidateSet/Way location of the invalidation
//   querySet         set whose victim is requested
//   replacementWay   lowest invalid way, or the LRU way when the set is full
//   setFull          every way of querySet is valid
module set_associative_replacement_unit
   import replacement_pkg::*;
#(
   parameter int NUMBER_OF_SETS = DEFAULT_NUMBER_OF_SETS,
   parameter int ASSOCIATIVITY  = DEFAULT_ASSOCIATIVITY,
   parameter int SET_WIDTH      = clog2_min1(NUMBER_OF_SETS),
   parameter int WAY_WIDTH      = $clog2(ASSOCIATIVITY)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 accessEnable,
   input  logic [SET_WIDTH-1:0] accessSet,
   input  logic [WAY_WIDTH-1:0] accessWay,
   input  logic                 invalidateEnable,
   input  logic [SET_WIDTH-1:0] invalidateSet,
   input  logic [WAY_WIDTH-1:0] invalidateWay,
   input  logic [SET_WIDTH-1:0] querySet,
   output logic [WAY_WIDTH-1:0] replacementWay,
   output logic                 setFull
);

   localparam age_t AGE_OLDEST = age_t'(ASSOCIATIVITY - 1);

   set_state_t state_q [NUMBER_OF_SETS];
   set_state_t state_d [NUMBER_OF_SETS];

   // One update block per set. The shared access/invalidate buses are decoded
   // into per-set enables, so events aimed at different sets in the same
   // cycle update independently.
   for (genvar s = 0; s < NUMBER_OF_SETS; s++) begin : g_set
      logic set_access_en;
      logic set_invalidate_en;

      assign set_access_en     = accessEnable     && (accessSet     == SET_WIDTH'(s));
      assign set_invalidate_en = invalidateEnable && (invalidateSet == SET_WIDTH'(s));

      lru_set_update #(
         .ASSOCIATIVITY (ASSOCIATIVITY),
         .WAY_WIDTH     (WAY_WIDTH)
      ) u_lru_set_update (
         .state_i          (state_q[s]),
         .access_en_i      (set_access_en),
         .access_way_i     (accessWay),
         .invalidate_en_i  (set_invalidate_en),
         .invalidate_way_i (invalidateWay),
         .state_o          (state_d[s])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NUMBER_OF_SETS; s++) begin
            state_q[s] <= reset_set_state();
         end
      end else begin
         for (int s = 0; s < NUMBER_OF_SETS; s++) begin
            state_q[s] <= state_d[s];
         end
      end
   end

   // Victim selection reads registered state only. A query of a set that is
   // being updated this cycle therefore sees the pre-update state.
   //   - Any invalid way wins, and the lowest index is taken (the descending
   //     scan leaves the lowest hit last).
   //   - Otherwise the way whose age equals ASSOCIATIVITY-1 is the LRU way.
   //     The permutation invariant guarantees there is exactly one such way.
   logic                 any_invalid;
   logic [WAY_WIDTH-1:0] first_invalid;
   logic [WAY_WIDTH-1:0] oldest_way;

   always_comb begin
      any_invalid   = 1'b0;
      first_invalid = '0;
      oldest_way    = '0;
      for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
         if (!state_q[querySet].valid[i]) begin
            any_invalid   = 1'b1;
            first_invalid = WAY_WIDTH'(i);
         end
      end
      for (int i = 0; i < ASSOCIATIVITY; i++) begin
         if (state_q[querySet].age[i] == AGE_OLDEST) begin
            oldest_way = WAY_WIDTH'(i);
         end
      end
      replacementWay = any_invalid ? first_invalid : oldest_way;
      setFull        = ~any_invalid;
   end

endmodule

// File: tb/tb_set_associative_replacement_unit.sv
// Self-checking bench for set_associative_replacement_unit (8 sets x 4 ways).
// Reference model: per set, a recency list (front = most recent) plus valid bits.
// Directed scenarios first, then randomized access/invalidate traffic.
module tb_set_associative_replacement_unit;

   localparam int NS   = 8;
   localparam int WAYS = 4;
   localparam int SW   = 3;
   localparam int WW   = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          accessEnable;
   logic [SW-1:0] accessSet;
   logic [WW-1:0] accessWay;
   logic          invalidateEnable;
   logic [SW-1:0] invalidateSet;
   logic [WW-1:0] invalidateWay;
   logic [SW-1:0] querySet;
   logic [WW-1:0] replacementWay;
   logic          setFull;

   int checks   = 0;
   int failures = 0;

   // Reference state: order[s][k] is the way with recency rank k.
   int order  [NS][$];
   bit mvalid [NS][WAYS];

   set_associative_replacement_unit #(
      .NUMBER_OF_SETS (NS),
      .ASSOCIATIVITY  (WAYS)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .accessEnable     (accessEnable),
      .accessSet        (accessSet),
      .accessWay        (accessWay),
      .invalidateEnable (invalidateEnable),
      .invalidateSet    (invalidateSet),
      .invalidateWay    (invalidateWay),
      .querySet         (querySet),
      .replacementWay   (replacementWay),
      .setFull          (setFull)
   );

   always #10 clock = ~clock;

   task automatic check_eq(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic void model_reset();
      for (int s = 0; s < NS; s++) begin
         order[s].delete();
         for (int w = 0; w < WAYS; w++) begin
            order[s].push_back(w);
            mvalid[s][w] = 1'b0;
         end
      end
   endfunction

   // Pull a way out of the recency list, then reinsert it as newest or oldest.
   function automatic void model_move(input int s, input int w, input bit to_front);
      for (int k = 0; k < order[s].size(); k++) begin
         if (order[s][k] == w) begin
            order[s].delete(k);
            break;
         end
      end
      if (to_front) order[s].push_front(w);
      else          order[s].push_back(w);
   endfunction

   function automatic void model_access(input int s, input int w);
      model_move(s, w, 1'b1);
      mvalid[s][w] = 1'b1;
   endfunction

   function automatic void model_invalidate(input int s, input int w);
      model_move(s, w, 1'b0);
      mvalid[s][w] = 1'b0;
   endfunction

   function automatic int model_victim(input int s);
      for (int w = 0; w < WAYS; w++) begin
         if (!mvalid[s][w]) return w;
      end
      return order[s][WAYS-1];
   endfunction

   function automatic int model_full(input int s);
      for (int w = 0; w < WAYS; w++) begin
         if (!mvalid[s][w]) return 0;
      end
      return 1;
   endfunction

   task automatic check_query(input string tag, input int s, input int exp_way, input int exp_full);
      querySet = SW'(s);
      #1;
      check_eq({tag, "_way"},  int'(replacementWay), exp_way);
      check_eq({tag, "_full"}, int'(setFull),        exp_full);
   endtask

   // One clock cycle of stimulus.
   // - While the enables are held, every set is swept against the
   //   pre-update model; this also covers the no-bypass rule.
   // - The model then absorbs the events at the clock edge, access before
   //   invalidate.
   task automatic cycle(input bit ae, input int as, input int aw,
                        input bit ie, input int is, input int iw);
      @(negedge clock);
      accessEnable     = ae;
      accessSet        = SW'(as);
      accessWay        = WW'(aw);
      invalidateEnable = ie;
      invalidateSet    = SW'(is);
      invalidateWay    = WW'(iw);
      for (int s = 0; s < NS; s++) begin
         querySet = SW'(s);
         #1;
         check_eq("sweep_way",  int'(replacementWay), model_victim(s));
         check_eq("sweep_full", int'(setFull),        model_full(s));
      end
      @(posedge clock);
      if (reset) begin
         if (ae) model_access(as, aw);
         if (ie) model_invalidate(is, iw);
      end
      #1;
      accessEnable     = 1'b0;
      invalidateEnable = 1'b0;
   endtask

   initial begin
      reset            = 1'b0;
      accessEnable     = 1'b0;
      accessSet        = '0;
      accessWay        = '0;
      invalidateEnable = 1'b0;
      invalidateSet    = '0;
      invalidateWay    = '0;
      querySet         = '0;
      model_reset();

      #5;
      check_query("reset_q3", 3, 0, 0);
      #20;
      reset = 1'b1;
      cycle(0, 0, 0, 0, 0, 0);

      // Set 5: fill in way order, then re-touch way 0.
      for (int w = 0; w < WAYS; w++) cycle(1, 5, w, 0, 0, 0);
      check_query("fill5", 5, 0, 1);
      cycle(1, 5, 0, 0, 0, 0);
      check_query("touch5", 5, 1, 1);

      // Set 2: fill, invalidate way 2, then refill it.
      for (int w = 0; w < WAYS; w++) cycle(1, 2, w, 0, 0, 0);
      cycle(0, 0, 0, 1, 2, 2);
      check_query("inv2", 2, 2, 0);
      cycle(1, 2, 2, 0, 0, 0);
      check_query("refill2", 2, 0, 1);

      // Set 1: access and invalidate of the same way in one cycle.
      cycle(1, 1, 3, 1, 1, 3);
      check_query("same1", 1, 0, 0);
      for (int w = 0; w < 3; w++) cycle(1, 1, w, 0, 0, 0);
      check_query("same1_fill", 1, 3, 0);

      // Sets 4 and 6: simultaneous events in different sets.
      for (int w = 0; w < WAYS; w++) cycle(1, 6, w, 0, 0, 0);
      cycle(1, 4, 0, 0, 0, 0);
      cycle(1, 4, 2, 0, 0, 0);
      cycle(1, 4, 3, 0, 0, 0);
      cycle(1, 4, 1, 1, 6, 0);
      check_query("cross4", 4, 0, 1);
      check_query("cross6", 6, 0, 0);

      // Set 7: fill, then re-touch way 0.
      for (int w = 0; w < WAYS; w++) cycle(1, 7, w, 0, 0, 0);
      cycle(1, 7, 0, 0, 0, 0);
      check_query("fill7", 7, 1, 1);

      // Mid-run reset: outputs must clear before any clock edge, and an access
      // presented while reset is low must be discarded.
      reset = 1'b0;
      #1;
      check_query("rst_async", 7, 0, 0);
      accessEnable = 1'b1;
      accessSet    = SW'(0);
      accessWay    = WW'(0);
      @(posedge clock);
      #1;
      accessEnable = 1'b0;
      reset        = 1'b1;
      model_reset();
      check_query("rst_discard", 0, 0, 0);
      check_query("rst_q7", 7, 0, 0);

      // Random traffic, with same-set collisions biased up.
      for (int n = 0; n < 500; n++) begin
         bit ae;
         bit ie;
         int as;
         int aw;
         int is;
         int iw;
         ae = ($urandom_range(0, 3) != 0);
         ie = ($urandom_range(0, 3) == 0);
         as = $urandom_range(0, NS - 1);
         aw = $urandom_range(0, WAYS - 1);
         is = ($urandom_range(0, 2) == 0) ? as : $urandom_range(0, NS - 1);
         iw = ($urandom_range(0, 3) == 0) ? aw : $urandom_range(0, WAYS - 1);
         cycle(ae, as, aw, ie, is, iw);
      end
      cycle(0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
